ro_vn_debiaser: RTL
===================

Name: ro_vn_debiaser

Overview:
- Upstream feeder of the 64-bit bit collector.
- Samples the asynchronous raw ring-oscillator XOR output at a programmable divided rate and removes bias with a von Neumann corrector.
- Emits single debiased bits as bit_out with a one-cycle bit_valid strobe; wires directly to the collector's bit_in and bit_valid.
- Also keeps a saturating count of discarded pairs for software statistics.

Parameters:
- SAMPLE_DIV, 16, clk cycles per sample tick; legal range 2..255.
- SYNC_STAGES, 2, flops in the raw_in synchroniser chain; legal range 2..4.
- RCT_CUTOFF, 32, repetition-count threshold; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run control; low = idle and clear pair state.
- raw_in  in  1  asynchronous raw RO XOR bit.
- bit_out  out  1  debiased bit; held between strobes.
- bit_valid  out  1  one-cycle strobe; bit_out is valid when high.
- discard_cnt  out  16  saturating count of discarded equal pairs.
- health_alarm  out  1  sticky repetition-count alarm; constant 0 without the optional feature.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). All flops clear on rst_n low: sync chain 0, div_cnt 0, FSM IDLE, bit_out 0, bit_valid 0, discard_cnt 0, health_alarm 0.
- Synchroniser: raw_in passes through SYNC_STAGES flops. s = last stage.
- Divider: div_cnt increments while enable=1 and wraps at SAMPLE_DIV-1. tick = enable && div_cnt==SAMPLE_DIV-1. While enable=0, div_cnt is held at 0.
- FSM states: IDLE, WAIT_FIRST, WAIT_SECOND.
  - IDLE -> WAIT_FIRST when enable=1.
  - Any state -> IDLE when enable=0. A pending first bit is dropped and nothing is emitted.
  - WAIT_FIRST: on tick, first_bit <= s; go to WAIT_SECOND.
  - WAIT_SECOND: on tick, if first_bit != s then bit_out <= first_bit and bit_valid <= 1. Otherwise discard_cnt increments, saturating at 16'hFFFF. Either way, go to WAIT_FIRST.
- Latency: bit_valid is high in the cycle after the second sample's tick cycle. It is high for exactly one cycle.
- Rate: at most one strobe per 2*SAMPLE_DIV cycles, so bit_valid is never high on consecutive cycles.
- First tick after enable rises: SAMPLE_DIV cycles after enable is sampled high.
- discard_cnt behaviour on enable: not cleared by enable; cleared only by rst_n.
- rst_n asserted mid-pair: immediate clear, no strobe. After release, operation starts from IDLE.
- No back-pressure: the downstream consumer must accept every strobe.

Optional Feature:
- Macro: RO_VN_RCT_EN.
- Defined:
  - rct_cnt (6 bits) counts consecutive identical emitted bits. It resets to 1 on each bit change and on the first bit after IDLE.
  - When rct_cnt reaches RCT_CUTOFF on an emitted bit, health_alarm sets, and that strobe and all later strobes are suppressed (bit_valid stays 0).
  - health_alarm is sticky until rst_n. The pair logic keeps running.
- Undefined: no rct logic; health_alarm tied 0; strobes are never suppressed.

Test Plan (SAMPLE_DIV=4, SYNC_STAGES=2):
1. Reset: hold rst_n=0 with raw_in toggling -> all outputs 0. Release with enable=0 for 20 cycles -> bit_valid never asserts, discard_cnt=0.
2. Unequal pairs: drive raw_in so the synced samples at ticks are 1,0 then 0,1 -> bit_out=1 strobe, then bit_out=0 strobe. Each strobe is one cycle, one cycle after the second tick, 8 cycles apart. discard_cnt stays 0.
3. Equal pairs: raw_in held 1 for 40 ticks -> no bit_valid, discard_cnt=20. raw_in held 0 for 10 more ticks -> discard_cnt=25.
4. Enable abort: drop enable one cycle after the first sample tick, then re-enable and supply 0,1 -> no strobe from the aborted pair. bit_out=0 strobe occurs 2*4 cycles after re-enable, plus one cycle.
5. Saturation: raw_in constant for 131,080 ticks -> discard_cnt reaches 16'hFFFF and stays there with no wrap to 0.
6. With RO_VN_RCT_EN defined and RCT_CUTOFF=32: repeat 1,0 pairs -> 31 strobes with bit_out=1. On the 32nd emitted bit health_alarm=1 and no strobe; no further strobes follow. Without the macro: 40 strobes occur and health_alarm stays 0.

Source files
------------

// File: rtl/ro_vn_debiaser.sv
// Ring-oscillator sampler with von Neumann debiasing and a saturating discard counter.
// Optional repetition-count health test enabled by defining RO_VN_RCT_EN.
module ro_vn_debiaser #(
  parameter int SAMPLE_DIV  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RCT_CUTOFF  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        raw_in,
  output logic        bit_out,
  output logic        bit_valid,
  output logic [15:0] discard_cnt,
  output logic        health_alarm
);

  if (SAMPLE_DIV < 2 || SAMPLE_DIV > 255) begin : g_bad_div
    $error("SAMPLE_DIV out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (RCT_CUTOFF < 1 || RCT_CUTOFF > 63) begin : g_bad_rct
    $error("RCT_CUTOFF out of range");
  end

  localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, WAIT_SECOND} state_t;

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   s;
  logic [7:0]             div_cnt;
  logic                   tick;
  state_t                 state, state_nxt;
  logic                   take_first, pair_done, emit, discard;
  logic                   first_bit;
  logic                   suppress;
  logic [15:0]            disc_q;

  // Stage: raw_in metastability chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p <= '0;
    else        sync_p <= {sync_p[SYNC_STAGES-2:0], raw_in};
  end

  assign s = sync_p[SYNC_STAGES-1];

  // Stage: sample-rate divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  div_cnt <= '0;
    else if (!enable)            div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 8'd1;
  end

  assign tick = enable && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:        state_nxt = WAIT_FIRST;
        WAIT_FIRST:  if (tick) state_nxt = WAIT_SECOND;
        WAIT_SECOND: if (tick) state_nxt = WAIT_FIRST;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    take_first = tick && (state == WAIT_FIRST);
    pair_done  = tick && (state == WAIT_SECOND);
    emit       = pair_done && (first_bit != s);
    discard    = pair_done && (first_bit == s);
  end

`ifdef RO_VN_RCT_EN
  localparam logic [5:0] RCT_LIM = 6'(RCT_CUTOFF);

  logic [5:0] rct_cnt, rct_nxt;
  logic       last_bit, rct_fresh, alarm_q;

  // A run restarts after any idle period or whenever the emitted bit flips.
  always_comb begin
    if (rct_fresh || (first_bit != last_bit)) rct_nxt = 6'd1;
    else if (rct_cnt == 6'h3F)                rct_nxt = rct_cnt;
    else                                      rct_nxt = rct_cnt + 6'd1;
  end

  assign suppress = alarm_q || (rct_nxt == RCT_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_cnt   <= '0;
      last_bit  <= 1'b0;
      rct_fresh <= 1'b1;
      alarm_q   <= 1'b0;
    end else begin
      if (state == IDLE) rct_fresh <= 1'b1;
      if (emit) begin
        rct_cnt   <= rct_nxt;
        last_bit  <= first_bit;
        rct_fresh <= 1'b0;
        if (rct_nxt == RCT_LIM) alarm_q <= 1'b1;
      end
    end
  end

  assign health_alarm = alarm_q;
`else
  assign suppress     = 1'b0;
  assign health_alarm = 1'b0;
`endif

  // Stage: pair capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_bit <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      disc_q    <= '0;
    end else begin
      bit_valid <= emit && !suppress;
      if (take_first) first_bit <= s;
      if (emit && !suppress) bit_out <= first_bit;
      if (discard && (disc_q != 16'hFFFF)) disc_q <= disc_q + 16'd1;
    end
  end

  assign discard_cnt = disc_q;

endmodule
